intr_arbiter: RTL
=================

# intr_arbiter

Interrupt arbiter placed between external interrupt sources and the single-cycle CPU's control unit. It synchronizes and edge-detects up to N request lines, holds them in a pending register, and gates them with a software mask. It drives the CU's single `intr` input and consumes the CU's `inta` acknowledge. It exposes the winning source ID and a small memory-mapped register file so the interrupt handler can read the source, clear it, and signal end-of-interrupt.

## Interface
- N, 8, number of interrupt sources (1..32)
- ID_W, 5, width of source ID (fixed; N ≤ 32)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- irq  in  N  raw interrupt lines, asynchronous to clk, rising-edge significant
- intr  out  1  interrupt request to CU (registered)
- inta  in  1  one-cycle acknowledge from CU (CU's int_int)
- intr_id  out  ID_W  ID of source being serviced (registered)
- busy  out  1  high while a source is in service
- we  in  1  register write strobe
- addr  in  2  register select
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr

## Operation
- Registers:
  - addr 0: MASK[N-1:0], R/W, 1 = enabled.
  - addr 1: PENDING[N-1:0], read; write-1-to-clear.
  - addr 2: read {25'b0, busy, 1'b0, intr_id}; writes ignored.
  - addr 3: EOI, a write of any value ends service; reads 0.
  - Unused upper bits read 0.
- Per-source 3-flop chain s1/s2/s3. edge[i] = s2[i] & ~s3[i].
- Pending update each cycle: pending_next = (pending & ~clr) | edge. clr comes from a W1C write and from the grant clear. Set wins over clear in the same cycle.
- Eligible set: elig = pending & MASK. Winner is the lowest eligible index (fixed priority, bit 0 highest).
- FSM states:
  - IDLE: intr=0, busy=0. Go to REQ when elig ≠ 0.
  - REQ: intr=1.
    - On inta=1: latch intr_id = winner computed in that cycle, clear that pending bit, go to SVC.
    - On inta=0 with elig = 0 (masked or cleared by software): withdraw and return to IDLE.
  - SVC: intr=0, busy=1. Go to IDLE on a write to addr 3.
    - New edges continue to set pending.
    - inta in SVC is ignored.
- inta received in IDLE is ignored; no state change.
- No nesting: only one source in service at a time.
- An EOI write outside SVC has no effect.
- If EOI and elig ≠ 0 occur together, the FSM goes SVC→IDLE this cycle and IDLE→REQ next cycle.
- MASK writes take effect on the next cycle's elig.

## Timing
- Reset values:
  - intr=0, busy=0, intr_id=0
  - MASK=0, PENDING=0
  - s1/s2/s3=0
  - state IDLE
  - rdata follows addr with reset register values.
- irq rising between clock edges 0 and 1:
  - s1=1 at edge 1, s2=1 at edge 2
  - PENDING bit set at edge 3
  - state=REQ and intr=1 after edge 4
- Grant: inta high in the cycle ending at edge k. At edge k: intr=0, busy=1, intr_id valid, pending bit cleared.
- EOI: a write at edge k gives busy=0 after edge k. Re-request: intr=1 after edge k+1 if anything is eligible.
- irq pulses shorter than one clock period may be missed. A held-high irq produces exactly one pending set per rising edge.
- rst asserted mid-REQ or mid-SVC: all outputs drop to reset values immediately (asynchronously). Any pending is lost.

## Test plan
- Reset then single source:
  - Stimulus: MASK=0x01, irq[0] rises before edge 1.
  - Response: intr=1 after edge 4. inta pulse gives intr_id=0, busy=1, PENDING=0. EOI write gives busy=0, intr stays 0.
- Priority:
  - Stimulus: MASK=0xFF, irq[5] and irq[2] rise together.
  - Response: first grant intr_id=2. After EOI, intr re-asserts the next cycle. Second grant intr_id=5.
- Masking and withdrawal:
  - Stimulus: MASK=0x00, irq[3] rises.
  - Response: PENDING=0x08, intr stays 0. Writing MASK=0x08 raises intr. Writing 0x08 to addr 1 while in REQ drops intr the next cycle, state IDLE.
- Simultaneous set and clear:
  - Stimulus: W1C of bit 1 in the same cycle as edge[1].
  - Response: PENDING[1]=1 afterwards.
- Spurious handshake and async reset:
  - Stimulus: inta pulse in IDLE.
  - Response: no change.
  - Stimulus: rst asserted mid-SVC.
  - Response: busy=0, intr_id=0, MASK=0 without waiting for a clock edge.

Source files
------------

// File: rtl/intr_arbiter.sv
// intr_arbiter: synchronizes and edge-detects N interrupt lines into a pending
// register, masks them, and runs a single-level request/acknowledge/EOI
// handshake with the CPU control unit. Small register file for the handler.
module intr_arbiter #(
    parameter int N    = 8,
    parameter int ID_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    irq,
    output logic            intr,
    input  logic            inta,
    output logic [ID_W-1:0] intr_id,
    output logic            busy,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SVC
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]    s1;
    logic [N-1:0]    s2;
    logic [N-1:0]    s3;
    logic [N-1:0]    rise;
    logic [N-1:0]    mask;
    logic [N-1:0]    pending;
    logic [N-1:0]    pending_next;
    logic [N-1:0]    elig;
    logic [N-1:0]    win_onehot;
    logic [N-1:0]    w1c_clr;
    logic [N-1:0]    clr;
    logic [ID_W-1:0] win_id;
    logic            grant;
    logic            eoi;
    logic            mask_we;
    logic            unused_wdata;

    assign unused_wdata = &{1'b0, wdata};

    assign mask_we = we && (addr == 2'd0);
    assign eoi     = we && (addr == 2'd3);
    assign w1c_clr = (we && (addr == 2'd1)) ? wdata[N-1:0] : '0;

    assign rise       = s2 & ~s3;
    assign elig       = pending & mask;
    assign win_onehot = elig & (~elig + N'(1));
    assign grant      = (state == REQ) && inta && (|elig);

    // A new edge always sets pending, even when software or a grant clears it.
    assign clr          = w1c_clr | (grant ? win_onehot : '0);
    assign pending_next = (pending & ~clr) | rise;

    // Fixed priority: the lowest eligible index wins, so scan downward.
    always_comb begin
        win_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // Two flops for metastability, a third to find the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Mask, pending and the serviced ID, which is latched only on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask    <= '0;
            pending <= '0;
            intr_id <= '0;
        end else begin
            pending <= pending_next;
            if (mask_we) begin
                mask <= wdata[N-1:0];
            end
            if (grant) begin
                intr_id <= win_id;
            end
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request when something is eligible; an ack with nothing eligible is
    // treated as a withdrawal rather than a grant of a stale source.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (|elig) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (grant) begin
                    state_next = SVC;
                end else if (!(|elig)) begin
                    state_next = IDLE;
                end
            end
            SVC: begin
                if (eoi) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs come straight from the state flops.
    always_comb begin
        intr = (state == REQ);
        busy = (state == SVC);
    end

    // Register read mux; unused bits and the EOI address read as zero.
    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata[N-1:0] = mask;
            2'd1: rdata[N-1:0] = pending;
            2'd2: begin
                rdata[6]        = busy;
                rdata[ID_W-1:0] = intr_id;
            end
            default: rdata = '0;
        endcase
    end

endmodule
